// File: rtl/duty_table_sequencer_if.sv
// Duty table read port: index out, table byte back after a fixed latency.
interface duty_table_bus_if;
  logic [15:0] idx;
  logic [7:0]  value;

  modport seq (output idx, input value);
  modport mem (input idx, output value);
endinterface

// File: rtl/duty_table_sequencer.sv
// Per-frame duty table lookup scheduler with overrun detection.
// Optional DUTY_TABLE_SEQ_BYPASS_EN: BYPASS selects idx[15:8] instead of VALUE.
module duty_table_sequencer #(
  parameter int DEPTH        = 249,
  parameter int READ_LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
`ifdef DUTY_TABLE_SEQ_BYPASS_EN
  input  logic       bypass,
`endif
  input  logic [7:0] mod,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_intensity,
  input  logic [7:0] in_phase,
  duty_table_bus_if.seq bus,
  output logic       out_valid,
  output logic [7:0] out_tr,
  output logic [7:0] out_pulse_width,
  output logic [7:0] out_phase,
  output logic       busy,
  output logic       done,
  output logic       overrun,
  input  logic       clr_overrun
);

  localparam int PD = READ_LATENCY + 2;
  localparam logic [7:0] LAST = 8'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t     state;
  logic [7:0] tr_cnt;
  logic [7:0] mod_l;
  logic [7:0] p_int;
  logic [PD-1:0] p_v;
  logic [7:0] p_tr [PD];
  logic [7:0] p_ph [PD];
  logic       acc;
  logic [7:0] pw_sel;

  assign acc = in_valid && in_ready;

`ifdef DUTY_TABLE_SEQ_BYPASS_EN
  logic        byp_l;
  logic [15:0] idx_d [2:PD-1];

  // idx copy kept in step with the table result
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 2; i < PD; i++) idx_d[i] <= '0;
    end else begin
      idx_d[2] <= bus.idx;
      for (int i = 3; i < PD; i++) idx_d[i] <= idx_d[i-1];
    end
  end

  assign pw_sel = byp_l ? idx_d[PD-1][15:8] : bus.value;
`else
  assign pw_sel = bus.value;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      in_ready        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      overrun         <= 1'b0;
      tr_cnt          <= '0;
      mod_l           <= '0;
      p_int           <= '0;
      p_v             <= '0;
      bus.idx         <= '0;
      out_valid       <= 1'b0;
      out_tr          <= '0;
      out_pulse_width <= '0;
      out_phase       <= '0;
`ifdef DUTY_TABLE_SEQ_BYPASS_EN
      byp_l           <= 1'b0;
`endif
      for (int i = 0; i < PD; i++) begin
        p_tr[i] <= '0;
        p_ph[i] <= '0;
      end
    end else begin
      done <= 1'b0;

      // set beats clear when both land together
      if (start && busy)    overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;

      p_v     <= {p_v[PD-2:0], acc};
      p_int   <= in_intensity;
      p_tr[0] <= tr_cnt;
      p_ph[0] <= in_phase;
      for (int i = 1; i < PD; i++) begin
        p_tr[i] <= p_tr[i-1];
        p_ph[i] <= p_ph[i-1];
      end

      bus.idx <= (state == IDLE) ? 16'd0
               : 16'(p_int) * 16'(mod_l);

      out_valid <= p_v[PD-1];
      if (p_v[PD-1]) begin
        out_tr          <= p_tr[PD-1];
        out_phase       <= p_ph[PD-1];
        out_pulse_width <= pw_sel;
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            mod_l    <= mod;
            tr_cnt   <= '0;
`ifdef DUTY_TABLE_SEQ_BYPASS_EN
            byp_l    <= bypass;
`endif
          end
        end
        RUN: begin
          if (in_valid) begin
            tr_cnt <= tr_cnt + 8'd1;
            if (tr_cnt == LAST) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // hold BUSY through the DONE cycle
          if (done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (p_v[PD-1] && p_tr[PD-1] == LAST) begin
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_duty_table_sequencer.sv
// Self-checking bench for duty_table_sequencer.
// Scoreboard of expected outputs keyed by cycle, plus directed vectors.
module tb_duty_table_sequencer;

  localparam int DEPTH = 249;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       clr_overrun = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] mod = '0;
  logic [7:0] in_intensity = '0;
  logic [7:0] in_phase = '0;
`ifdef DUTY_TABLE_SEQ_BYPASS_EN
  logic       bypass = 1'b0;
`endif
  logic       in_ready, out_valid, busy, done, overrun;
  logic [7:0] out_tr, out_pulse_width, out_phase;

  duty_table_bus_if bus();

  logic [7:0] tbl [65536];
  logic [7:0] r1;

  // two-cycle table read
  always @(posedge clk) begin
    r1 <= tbl[bus.idx];
    bus.value <= r1;
  end

  always #5 clk = ~clk;

  duty_table_sequencer dut (
    .clk(clk),
    .rst(rst),
    .start(start),
`ifdef DUTY_TABLE_SEQ_BYPASS_EN
    .bypass(bypass),
`endif
    .mod(mod),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_intensity(in_intensity),
    .in_phase(in_phase),
    .bus(bus),
    .out_valid(out_valid),
    .out_tr(out_tr),
    .out_pulse_width(out_pulse_width),
    .out_phase(out_phase),
    .busy(busy),
    .done(done),
    .overrun(overrun),
    .clr_overrun(clr_overrun)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: queues of expectations due at a given negedge
  typedef struct { int due; int tr; int pw; int ph; } oexp_t;
  typedef struct { int due; int idx; } iexp_t;
  oexp_t oq[$];
  iexp_t iq[$];
  int n = 0;
  bit m_ready = 0, m_busy = 0, m_ovr = 0, m_byp = 0;
  int m_cnt = 0, m_mod = 0;
  bit dn;
  int ix;

  always @(negedge clk) begin
    n++;
    dn = 0;
    chk("in_ready", in_ready, m_ready);
    chk("busy", busy, m_busy);
    chk("overrun", overrun, m_ovr);
    if (iq.size() > 0 && iq[0].due == n) begin
      chk("idx", bus.idx, iq[0].idx);
      void'(iq.pop_front());
    end
    if (oq.size() > 0 && oq[0].due == n) begin
      chk("out_valid", out_valid, 1);
      chk("out_tr", out_tr, oq[0].tr);
      chk("out_pw", out_pulse_width, oq[0].pw);
      chk("out_phase", out_phase, oq[0].ph);
      dn = (oq[0].tr == DEPTH - 1);
      void'(oq.pop_front());
    end else begin
      chk("out_valid", out_valid, 0);
    end
    chk("done", done, dn);

    if (rst) begin
      oq.delete();
      iq.delete();
      m_ready = 0;
      m_busy = 0;
      m_ovr = 0;
      m_cnt = 0;
    end else begin
      if (in_valid && m_ready) begin
        ix = int'(in_intensity) * m_mod;
        iq.push_back('{n + 2, ix});
        oq.push_back('{n + 5, m_cnt,
                       m_byp ? (ix >> 8) : int'(tbl[ix]),
                       int'(in_phase)});
        m_cnt++;
        if (m_cnt == DEPTH) m_ready = 0;
      end
      if (start && m_busy) m_ovr = 1;
      else if (clr_overrun) m_ovr = 0;
      if (start && !m_busy) begin
        m_busy = 1;
        m_ready = 1;
        m_cnt = 0;
        m_mod = int'(mod);
`ifdef DUTY_TABLE_SEQ_BYPASS_EN
        m_byp = bypass;
`endif
      end
      if (dn) m_busy = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_idx", bus.idx, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_tr", out_tr, 0);
    chk("rst_out_pw", out_pulse_width, 0);
    chk("rst_out_phase", out_phase, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
  endtask

  // one frame; ovr_at/abort_at are sample counts (-1 = unused)
  task automatic frame(input int m, input int first, input int gaps,
                       input int ovr_at, input bit clr_too,
                       input int abort_at, input bit sod,
                       input int exp_idx, input int exp_pw);
    int sent = 0;
    int since = -1;
    int guard = 0;
    int k = 0;
    bit aborted = 0;
    mod = m[7:0];
    start = 1;
    tick();
    start = 0;
    mod = 8'($urandom);
    while (sent < DEPTH && guard < 3000) begin
      guard++;
      in_valid = (sent == 0) || gaps == 0 || $urandom_range(99) >= gaps;
      in_intensity = (sent == 0) ? first[7:0] : 8'($urandom);
      in_phase = 8'($urandom);
      start = (sent == ovr_at) && in_valid;
      clr_overrun = start && clr_too;
      rst = (sent == abort_at);
      tick();
      start = 0;
      clr_overrun = 0;
      if (rst) begin
        rst = 0;
        in_valid = 0;
        aborted = 1;
        chk_reset_outs();
        break;
      end
      if (in_valid) sent++;
      if (since >= 0) since++;
      if (sent == 1 && since < 0) since = 0;
      if (since == 1 && exp_idx >= 0) chk("vec_idx", bus.idx, exp_idx);
      if (since == 4 && exp_pw >= 0) begin
        chk("vec_valid", out_valid, 1);
        chk("vec_pw", out_pulse_width, exp_pw);
      end
    end
    in_valid = 0;
    if (aborted) begin
      repeat (12) tick();
      chk("abort_idle", busy, 0);
      return;
    end
    chk("frame_sent", sent, DEPTH);
    while (!done && k < 20) begin
      tick();
      k++;
    end
    chk("done_seen", done, 1);
    if (gaps == 0) chk("done_latency", k, 4);
    if (sod) begin
      start = 1;
      tick();
      start = 0;
    end
    repeat (3) tick();
    chk("end_busy", busy, 0);
  endtask

  typedef struct { int m; int in; int ex_idx; } vec_t;
  vec_t vt[4];

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{255, 255, 65025};
    vt[1] = '{255, 0, 0};
    vt[2] = '{128, 200, 25600};
    vt[3] = '{3, 7, 21};
    for (int i = 0; i < 65536; i++) tbl[i] = 8'($urandom);

    repeat (3) tick();
    rst = 0;
    chk_reset_outs();
    tick();

    for (int i = 0; i < 4; i++)
      frame(vt[i].m, vt[i].in, 0, -1, 0, -1, 0,
            vt[i].ex_idx, int'(tbl[vt[i].ex_idx]));

    frame(255, 17, 0, -1, 0, -1, 0, -1, -1);
    frame($urandom_range(255), 9, 35, -1, 0, -1, 0, -1, -1);

    frame(77, 5, 0, 100, 0, -1, 0, -1, -1);
    chk("ovr_sticky", overrun, 1);
    frame(91, 6, 0, 60, 1, -1, 0, -1, -1);
    chk("ovr_set_wins", overrun, 1);
    clr_overrun = 1;
    tick();
    clr_overrun = 0;
    chk("ovr_clr", overrun, 0);

    frame(200, 3, 0, -1, 0, -1, 1, -1, -1);
    chk("ovr_on_done", overrun, 1);
    clr_overrun = 1;
    tick();
    clr_overrun = 0;
    chk("ovr_clr2", overrun, 0);

    frame(150, 4, 0, -1, 0, 50, 0, -1, -1);
    frame(150, 4, 0, -1, 0, -1, 0, 600, int'(tbl[600]));

`ifdef DUTY_TABLE_SEQ_BYPASS_EN
    bypass = 1;
    frame(128, 200, 0, -1, 0, -1, 0, 25600, 100);
    bypass = 0;
`endif

    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
